rf_writeback_queue: RTL

- Write-side front end of the 32x32 register file in the 5-stage pipeline.
- Accepts completed results from two producers:
  - Port A: the in-order MEM/WB result, high priority.
  - Port B: the multi-cycle mul/div unit.
- Buffers results in a small in-order FIFO and drains one per cycle into the register file's single write port (regWrite/wn/wd).
- Exposes a pending-write scoreboard and an optional forwarding path to decode.

---
 rtl/rf_wb_pkg.sv | 19 +
 rtl/rf_wb_match.sv | 58 +++++
 rtl/rf_writeback_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
// The optional decode-forwarding path is enabled by defining WB_FORWARD_EN.
package rf_wb_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int WB_ADDR_W     = 5;
  localparam int WB_DATA_W     = 32;

  // Writes that target this index are architecturally discarded.
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  // One queued register-file write. The queue uses these widths for its
  // storage, so the top-level ADDR_W/DATA_W must equal WB_ADDR_W/WB_DATA_W.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] wn;
    logic [WB_DATA_W-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_match.sv
// Per-source-index matcher over queued writes plus the output register.
// Produces the pending flag and, when WB_FORWARD_EN is defined, the data of
// the youngest matching write. Entries arrive in age order (index 0 = oldest).
module rf_wb_match
  import rf_wb_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [ADDR_W-1:0]             chk_rn,
  input  logic [DEPTH-1:0]              ent_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  ent_wn,
  input  logic                          out_valid,
  input  logic [ADDR_W-1:0]             out_wn,
`ifdef WB_FORWARD_EN
  input  logic [DEPTH-1:0][DATA_W-1:0]  ent_wd,
  input  logic [DATA_W-1:0]             out_wd,
`endif
  output logic                          pend,
  output logic                          fwd_hit,
  output logic [DATA_W-1:0]             fwd_data
);

  logic [DEPTH-1:0] ent_hit;
  logic             out_hit;

  // Compare the source index against every live queue slot.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_hit[k] = ent_valid[k] && (ent_wn[k] == chk_rn);
    end
  end

  assign out_hit = out_valid && (out_wn == chk_rn);
  assign pend    = (chk_rn != ADDR_W'(REG_ZERO)) && ((|ent_hit) || out_hit);

`ifdef WB_FORWARD_EN
  // Youngest match wins: output register is oldest, later queue slots override.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned and infers a latch.
    fwd_data = '0;
    if (pend) begin
      if (out_hit) fwd_data = out_wd;
      for (int k = 0; k < DEPTH; k++) begin
        if (ent_hit[k]) fwd_data = ent_wd[k];
      end
    end
  end

  assign fwd_hit = pend;
`else
  // Forwarding absent: decode stalls on pend instead.
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-side front end of the 32x32 register file. Merges the in-order
// MEM/WB result (port A, priority) and the mul/div result (port B) into an
// in-order FIFO that drains one write per cycle into regWrite/wn/wd.
// Define WB_FORWARD_EN to enable forwarding of queued data to decode.
module rf_writeback_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [ADDR_W-1:0]            a_wn,
  input  logic [DATA_W-1:0]            a_wd,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [ADDR_W-1:0]            b_wn,
  input  logic [DATA_W-1:0]            b_wd,
  output logic                         regWrite,
  output logic [ADDR_W-1:0]            wn,
  output logic [DATA_W-1:0]            wd,
  input  logic [ADDR_W-1:0]            chk_rn1,
  input  logic [ADDR_W-1:0]            chk_rn2,
  output logic                         pend1,
  output logic                         pend2,
  output logic                         fwd_hit1,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  b_slot;
  logic [CNT_W-1:0]  count;
  logic              a_accept;
  logic              b_accept;
  logic              a_push;
  logic              b_push;
  logic              pop;

  // Ready depends only on the registered occupancy; a same-cycle pop earns no
  // credit. B sees the slot A is about to take, so A wins the last free slot.
  assign a_ready  = rst_n && (count < FULL);
  assign a_accept = a_valid && a_ready;
  assign b_ready  = rst_n && ((count + CNT_W'(a_accept)) < FULL);
  assign b_accept = b_valid && b_ready;

  // Writes to r0 complete the handshake but are dropped.
  assign a_push = a_accept && (a_wn != ADDR_W'(REG_ZERO));
  assign b_push = b_accept && (b_wn != ADDR_W'(REG_ZERO));
  assign pop    = (count != '0);
  assign b_slot = wr_ptr + PTR_W'(a_push);
  assign level  = count;

  // Store accepted results: A at the tail, B directly behind it.
  // NOTE: the storage array is deliberately not reset; count alone decides which slots are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (a_push) mem[wr_ptr] <= '{wn: a_wn, wd: a_wd};
    if (b_push) mem[b_slot] <= '{wn: b_wn, wd: b_wd};
  end

  // Pointer/occupancy bookkeeping and the registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      regWrite <= 1'b0;
      wn       <= '0;
      wd       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
      wr_ptr   <= wr_ptr + PTR_W'(a_push) + PTR_W'(b_push);
      count    <= count + CNT_W'(a_push) + CNT_W'(b_push) - CNT_W'(pop);
      regWrite <= pop;
      if (pop) begin
        wn     <= mem[rd_ptr].wn;
        wd     <= mem[rd_ptr].wd;
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Age-ordered view of the queue for the matchers (index 0 = head/oldest).
  logic [DEPTH-1:0][ADDR_W-1:0] age_wn;
  logic [DEPTH-1:0]             age_valid;
`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0][DATA_W-1:0] age_wd;
`endif

  // Rotate storage by the read pointer and mark slots below count as live.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_wn[k]    = mem[rd_ptr + PTR_W'(k)].wn;
      age_valid[k] = (CNT_W'(k) < count);
`ifdef WB_FORWARD_EN
      age_wd[k]    = mem[rd_ptr + PTR_W'(k)].wd;
`endif
    end
  end

  rf_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match1 (
    .chk_rn    (chk_rn1),
    .ent_valid (age_valid),
    .ent_wn    (age_wn),
    .out_valid (regWrite),
    .out_wn    (wn),
`ifdef WB_FORWARD_EN
    .ent_wd    (age_wd),
    .out_wd    (wd),
`endif
    .pend      (pend1),
    .fwd_hit   (fwd_hit1),
    .fwd_data  (fwd_data1)
  );

  rf_wb_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match2 (
    .chk_rn    (chk_rn2),
    .ent_valid (age_valid),
    .ent_wn    (age_wn),
    .out_valid (regWrite),
    .out_wn    (wn),
`ifdef WB_FORWARD_EN
    .ent_wd    (age_wd),
    .out_wd    (wd),
`endif
    .pend      (pend2),
    .fwd_hit   (fwd_hit2),
    .fwd_data  (fwd_data2)
  );

endmodule
